// File: rtl/noc_credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : noc_credit_link_tx
// Description : Transmit end of a credit-based router-to-router link. It takes
//               flits from a local valid/ready source and registers them onto
//               the link with one cycle of latency. It keeps a credit counter
//               that mirrors the downstream input buffer, and it checks that a
//               packet keeps a single destination up to its tail flit.
// Ports       : clk, rst_n                 clock, async active-low reset
//               flit_valid/flit_ready      local source handshake
//               flit_data/dest/is_tail     flit from the source
//               data_out/dest_out          registered link payload/destination
//               is_tail_out/send_out       link tail marker, one-cycle send pulse
//               credit_in                  one pulse per freed downstream slot
//               credit_count               credits currently available
//               pkt_count                  tail flits sent (wrapping)
//               err_credit_overflow        sticky, credit while counter full
//               err_dest_change            sticky, dest changed inside a packet
//               stall_cycles               stall statistics (0 when disabled)
// Options     : NOC_CREDIT_TX_STALL_STATS_EN enables the saturating counter of
//               cycles where flit_valid is high and no credits are left.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_credit_link_tx #(
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int PKT_CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flit_valid,
  output logic                     flit_ready,
  input  logic [FLIT_WIDTH-1:0]    flit_data,
  input  logic [DEST_WIDTH-1:0]    flit_dest,
  input  logic                     flit_is_tail,
  output logic [FLIT_WIDTH-1:0]    data_out,
  output logic [DEST_WIDTH-1:0]    dest_out,
  output logic                     is_tail_out,
  output logic                     send_out,
  input  logic                     credit_in,
  output logic [CREDIT_WIDTH-1:0]  credit_count,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                     err_credit_overflow,
  output logic                     err_dest_change,
  output logic [31:0]              stall_cycles
);

  localparam logic [CREDIT_WIDTH-1:0] C_CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] C_CREDIT_ONE = CREDIT_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [DEST_WIDTH-1:0]    r_pkt_dest;
  logic [DEST_WIDTH-1:0]    w_pkt_dest_next;
  logic                     w_dest_mismatch;

  logic [CREDIT_WIDTH-1:0]  r_credit;
  logic [CREDIT_WIDTH-1:0]  w_credit_next;
  logic                     w_credit_overflow;
  logic                     w_accept;

  logic                     r_send;
  logic                     r_is_tail;
  logic [FLIT_WIDTH-1:0]    r_data;
  logic [DEST_WIDTH-1:0]    r_dest;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_count;
  logic                     r_err_overflow;
  logic                     r_err_dest;

  // Ready depends only on the registered count, so a credit that arrives
  // at zero becomes visible one cycle later.
  assign flit_ready = (r_credit != '0);
  assign w_accept   = flit_valid && flit_ready;

  // Credit bookkeeping: next = count - accept + credit_in, saturating at
  // the buffer depth. An accept needs count > 0, so the counter cannot
  // underflow.
  always_comb begin
    w_credit_next     = r_credit;
    w_credit_overflow = 1'b0;
    case ({w_accept, credit_in})
      2'b10: w_credit_next = r_credit - C_CREDIT_ONE;
      2'b01: begin
        if (r_credit == C_CREDIT_MAX) begin
          w_credit_overflow = 1'b1;
        end else begin
          w_credit_next = r_credit + C_CREDIT_ONE;
        end
      end
      default: w_credit_next = r_credit;
    endcase
  end

  // Framing checker next-state logic. A mismatching flit is still forwarded.
  always_comb begin
    w_state_next    = r_state;
    w_pkt_dest_next = r_pkt_dest;
    w_dest_mismatch = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (!flit_is_tail) begin
            w_state_next    = BODY;
            w_pkt_dest_next = flit_dest;
          end
        end
        BODY: begin
          w_dest_mismatch = (flit_dest != r_pkt_dest);
          if (flit_is_tail) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pkt_dest <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pkt_dest <= w_pkt_dest_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit       <= C_CREDIT_MAX;
      r_send         <= 1'b0;
      r_is_tail      <= 1'b0;
      r_data         <= '0;
      r_dest         <= '0;
      r_pkt_count    <= '0;
      r_err_overflow <= 1'b0;
      r_err_dest     <= 1'b0;
    end else begin
      r_credit <= w_credit_next;
      r_send   <= w_accept;
      // Payload fields hold their last value while nothing is sent.
      if (w_accept) begin
        r_data    <= flit_data;
        r_dest    <= flit_dest;
        r_is_tail <= flit_is_tail;
      end
      if (r_send && r_is_tail) begin
        r_pkt_count <= r_pkt_count + PKT_CNT_WIDTH'(1);
      end
      if (w_credit_overflow) begin
        r_err_overflow <= 1'b1;
      end
      if (w_dest_mismatch) begin
        r_err_dest <= 1'b1;
      end
    end
  end

  assign credit_count        = r_credit;
  assign send_out            = r_send;
  assign is_tail_out         = r_is_tail;
  assign data_out            = r_data;
  assign dest_out            = r_dest;
  assign pkt_count           = r_pkt_count;
  assign err_credit_overflow = r_err_overflow;
  assign err_dest_change     = r_err_dest;

`ifdef NOC_CREDIT_TX_STALL_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (flit_valid && (r_credit == '0) && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_credit_link_tx
// Description : Self-checking bench for noc_credit_link_tx (default params).
//               Runs a table of per-cycle vectors and then hand-written
//               sequences for a mid-packet reset and stall statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_credit_link_tx;

  logic        clk;
  logic        rst_n;
  logic        flit_valid;
  logic        flit_ready;
  logic [63:0] flit_data;
  logic [3:0]  flit_dest;
  logic        flit_is_tail;
  logic [63:0] data_out;
  logic [3:0]  dest_out;
  logic        is_tail_out;
  logic        send_out;
  logic        credit_in;
  logic [1:0]  credit_count;
  logic [15:0] pkt_count;
  logic        err_credit_overflow;
  logic        err_dest_change;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  noc_credit_link_tx dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flit_valid          (flit_valid),
    .flit_ready          (flit_ready),
    .flit_data           (flit_data),
    .flit_dest           (flit_dest),
    .flit_is_tail        (flit_is_tail),
    .data_out            (data_out),
    .dest_out            (dest_out),
    .is_tail_out         (is_tail_out),
    .send_out            (send_out),
    .credit_in           (credit_in),
    .credit_count        (credit_count),
    .pkt_count           (pkt_count),
    .err_credit_overflow (err_credit_overflow),
    .err_dest_change     (err_dest_change),
    .stall_cycles        (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle, and the outputs expected in that same cycle
  // (before the edge that consumes the inputs).
  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [3:0]  dst;
    logic        t;
    logic        cr;
    logic        rdy;
    logic        snd;
    logic [63:0] ed;
    logic [3:0]  edst;
    logic        et;
    logic [1:0]  cc;
    logic [15:0] pkt;
    logic        eovf;
    logic        edc;
  } vec_t;

  localparam int N_VEC = 25;
  vec_t tbl [N_VEC];

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [3:0] dst,
                              input logic t, input logic cr, input logic rdy, input logic snd,
                              input logic [63:0] ed, input logic [3:0] edst, input logic et,
                              input logic [1:0] cc, input logic [15:0] pkt,
                              input logic eovf, input logic edc);
    vec_t r;
    r.v = v; r.d = d; r.dst = dst; r.t = t; r.cr = cr;
    r.rdy = rdy; r.snd = snd; r.ed = ed; r.edst = edst; r.et = et;
    r.cc = cc; r.pkt = pkt; r.eovf = eovf; r.edc = edc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //             v  data    dst   t  cr  rdy snd exp_data exp_dst et cc pkt eovf edc
    // reset, idle
    tbl[0]  = mk(0, 64'h0,  4'h0, 0, 0,  1, 0, 64'h0,  4'h0, 0, 2, 0, 0, 0);
    // credit exhaustion: three flits to dest 1, credit returned in row 6
    tbl[1]  = mk(1, 64'hA0, 4'h1, 0, 0,  1, 0, 64'h0,  4'h0, 0, 2, 0, 0, 0);
    tbl[2]  = mk(1, 64'hA1, 4'h1, 0, 0,  1, 1, 64'hA0, 4'h1, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 64'hA2, 4'h1, 1, 0,  0, 1, 64'hA1, 4'h1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 64'hA2, 4'h1, 1, 0,  0, 0, 64'h0,  4'h0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 64'hA2, 4'h1, 1, 0,  0, 0, 64'h0,  4'h0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 64'hA2, 4'h1, 1, 1,  0, 0, 64'h0,  4'h0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 64'hA2, 4'h1, 1, 0,  1, 0, 64'h0,  4'h0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 64'h0,  4'h0, 0, 0,  0, 1, 64'hA2, 4'h1, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 64'h0,  4'h0, 0, 1,  0, 0, 64'h0,  4'h0, 0, 0, 1, 0, 0);
    // simultaneous accept and credit at count 1
    tbl[10] = mk(1, 64'hB0, 4'h2, 1, 1,  1, 0, 64'h0,  4'h0, 0, 1, 1, 0, 0);
    tbl[11] = mk(0, 64'h0,  4'h0, 0, 0,  1, 1, 64'hB0, 4'h2, 1, 1, 1, 0, 0);
    tbl[12] = mk(0, 64'h0,  4'h0, 0, 1,  1, 0, 64'h0,  4'h0, 0, 1, 2, 0, 0);
    // credit overflow at full count
    tbl[13] = mk(0, 64'h0,  4'h0, 0, 1,  1, 0, 64'h0,  4'h0, 0, 2, 2, 0, 0);
    tbl[14] = mk(0, 64'h0,  4'h0, 0, 0,  1, 0, 64'h0,  4'h0, 0, 2, 2, 1, 0);
    // 3-flit packet to dest 5, then single flit to dest A (credit returned each accept)
    tbl[15] = mk(1, 64'hC0, 4'h5, 0, 1,  1, 0, 64'h0,  4'h0, 0, 2, 2, 1, 0);
    tbl[16] = mk(1, 64'hC1, 4'h5, 0, 1,  1, 1, 64'hC0, 4'h5, 0, 2, 2, 1, 0);
    tbl[17] = mk(1, 64'hC2, 4'h5, 1, 1,  1, 1, 64'hC1, 4'h5, 0, 2, 2, 1, 0);
    tbl[18] = mk(1, 64'hD0, 4'hA, 1, 1,  1, 1, 64'hC2, 4'h5, 1, 2, 2, 1, 0);
    tbl[19] = mk(0, 64'h0,  4'h0, 0, 0,  1, 1, 64'hD0, 4'hA, 1, 2, 3, 1, 0);
    tbl[20] = mk(0, 64'h0,  4'h0, 0, 0,  1, 0, 64'h0,  4'h0, 0, 2, 4, 1, 0);
    // 2-flit packet whose dest changes from 3 to 7
    tbl[21] = mk(1, 64'hE0, 4'h3, 0, 1,  1, 0, 64'h0,  4'h0, 0, 2, 4, 1, 0);
    tbl[22] = mk(1, 64'hE1, 4'h7, 1, 1,  1, 1, 64'hE0, 4'h3, 0, 2, 4, 1, 0);
    tbl[23] = mk(0, 64'h0,  4'h0, 0, 0,  1, 1, 64'hE1, 4'h7, 1, 2, 4, 1, 1);
    tbl[24] = mk(0, 64'h0,  4'h0, 0, 0,  1, 0, 64'h0,  4'h0, 0, 2, 5, 1, 1);

    rst_n        = 1'b0;
    flit_valid   = 1'b0;
    flit_data    = '0;
    flit_dest    = '0;
    flit_is_tail = 1'b0;
    credit_in    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      flit_valid   = tbl[i].v;
      flit_data    = tbl[i].d;
      flit_dest    = tbl[i].dst;
      flit_is_tail = tbl[i].t;
      credit_in    = tbl[i].cr;
      #1;
      chk($sformatf("row%0d flit_ready", i), 64'(flit_ready), 64'(tbl[i].rdy));
      chk($sformatf("row%0d send_out", i), 64'(send_out), 64'(tbl[i].snd));
      chk($sformatf("row%0d credit_count", i), 64'(credit_count), 64'(tbl[i].cc));
      chk($sformatf("row%0d pkt_count", i), 64'(pkt_count), 64'(tbl[i].pkt));
      chk($sformatf("row%0d err_credit_overflow", i), 64'(err_credit_overflow), 64'(tbl[i].eovf));
      chk($sformatf("row%0d err_dest_change", i), 64'(err_dest_change), 64'(tbl[i].edc));
      if (tbl[i].snd) begin
        chk($sformatf("row%0d data_out", i), data_out, tbl[i].ed);
        chk($sformatf("row%0d dest_out", i), 64'(dest_out), 64'(tbl[i].edst));
        chk($sformatf("row%0d is_tail_out", i), 64'(is_tail_out), 64'(tbl[i].et));
      end
    end

    // Reset while a non-tail flit is in flight
    @(negedge clk);
    flit_valid   = 1'b1;
    flit_data    = 64'hF0;
    flit_dest    = 4'h9;
    flit_is_tail = 1'b0;
    credit_in    = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst send before reset", 64'(send_out), 64'd1);
    chk("midrst credit before reset", 64'(credit_count), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst send_out", 64'(send_out), 64'd0);
    chk("midrst credit_count", 64'(credit_count), 64'd2);
    chk("midrst pkt_count", 64'(pkt_count), 64'd0);
    chk("midrst err_credit_overflow", 64'(err_credit_overflow), 64'd0);
    chk("midrst err_dest_change", 64'(err_dest_change), 64'd0);
    chk("midrst stall_cycles", 64'(stall_cycles), 64'd0);
    flit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Stall statistics: two single-flit packets drain the credits, then
    // flit_valid stays high for 10 more cycles with zero credits.
    @(negedge clk);
    flit_valid   = 1'b1;
    flit_data    = 64'h55;
    flit_dest    = 4'h0;
    flit_is_tail = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("stall credit_count", 64'(credit_count), 64'd0);
    chk("stall flit_ready", 64'(flit_ready), 64'd0);
`ifdef NOC_CREDIT_TX_STALL_STATS_EN
    chk("stall stall_cycles", 64'(stall_cycles), 64'd10);
`else
    chk("stall stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    flit_valid = 1'b0;
    @(negedge clk);
    #1;
`ifdef NOC_CREDIT_TX_STALL_STATS_EN
    chk("stall hold stall_cycles", 64'(stall_cycles), 64'd10);
`else
    chk("stall hold stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    chk("stall pkt_count", 64'(pkt_count), 64'd2);
    chk("stall err_dest_change", 64'(err_dest_change), 64'd0);
    chk("stall err_credit_overflow", 64'(err_credit_overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_credit_link_tx.md
Name: noc_credit_link_tx

Overview:
- Transmitting end of the credit-based router-to-router link (data/dest/is_tail/send out, credit in).
- Accepts flits from a local valid/ready source, e.g. a serializer shim or a test traffic generator.
- Drives a router input port, holding a credit counter that mirrors that port's flit buffer.
- Checks packet framing: a packet keeps one dest until its tail flit.

Parameters:
- FLIT_WIDTH, 64, data bits per flit
- DEST_WIDTH, 4, destination field width
- FLIT_BUFFER_DEPTH, 2, downstream input buffer depth in flits; initial and maximum credit count (>=1)
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived, do not override)
- PKT_CNT_WIDTH, 16, width of the sent-packet counter

Ports:
- clk  in  1  clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- flit_valid  in  1  source has a flit
- flit_ready  out  1  block accepts the flit this cycle
- flit_data  in  FLIT_WIDTH  flit payload
- flit_dest  in  DEST_WIDTH  flit destination
- flit_is_tail  in  1  last flit of the packet
- data_out  out  FLIT_WIDTH  link payload
- dest_out  out  DEST_WIDTH  link destination
- is_tail_out  out  1  link tail marker
- send_out  out  1  one-cycle pulse per flit on the link
- credit_in  in  1  one-cycle pulse per freed downstream slot
- credit_count  out  CREDIT_WIDTH  current credits available
- pkt_count  out  PKT_CNT_WIDTH  tail flits sent, wraps modulo 2^PKT_CNT_WIDTH
- err_credit_overflow  out  1  sticky: a credit arrived while the counter was full
- err_dest_change  out  1  sticky: dest changed inside a packet
- stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async assert, sync use after deassert) sets:
  - send_out, is_tail_out, data_out, dest_out, pkt_count, both error flags, stall_cycles to 0
  - credit_count to FLIT_BUFFER_DEPTH
  - state to IDLE
- flit_ready = (credit_count != 0), derived from the registered count only. There is no combinational path from credit_in or flit_valid to flit_ready.
- Accept = flit_valid && flit_ready.
- On accept at cycle N, in cycle N+1:
  - send_out=1
  - data_out/dest_out/is_tail_out carry the accepted flit
- Latency is exactly 1 cycle. Back-to-back accepts give continuous send_out.
- Without accept, send_out=0 next cycle. data_out/dest_out/is_tail_out hold their last values; is_tail_out is meaningful only with send_out.
- Credit update per cycle: next = count - accept + credit_in.
  - Simultaneous accept and credit_in: count unchanged.
  - credit_in with count == FLIT_BUFFER_DEPTH and no accept: count stays at FLIT_BUFFER_DEPTH (saturate) and err_credit_overflow is set.
  - Count never underflows, because accept requires count > 0.
- A credit arriving at count 0 raises flit_ready in the next cycle, not the same cycle.
- Framing FSM:
  - IDLE: an accept of a non-tail flit latches flit_dest into pkt_dest and moves to BODY. An accept of a tail flit (single-flit packet) stays in IDLE.
  - BODY: every accept compares flit_dest with pkt_dest; a mismatch sets err_dest_change (the flit is still sent unchanged). An accept with tail returns to IDLE.
- pkt_count increments by 1 in the cycle send_out && is_tail_out is high.
- Error flags clear only on reset.
- Reset asserted mid-packet discards any in-flight flit. The next cycle shows send_out=0, and credits return to FLIT_BUFFER_DEPTH. The downstream router must be reset together with this block.

Optional Feature:
- Macro: NOC_CREDIT_TX_STALL_STATS_EN.
- Defined: stall_cycles is a 32-bit saturating counter. It increments every cycle with flit_valid=1 and credit_count=0, and resets to 0.
- Undefined: the counter logic is not instantiated and stall_cycles is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset then idle:
  - Required values: credit_count=2, flit_ready=1, send_out=0, pkt_count=0, both errors 0.
- Credit exhaustion (DEPTH=2, credit_in held 0): drive 3 flits valid continuously from cycle 0.
  - Flits 0 and 1 go out with send_out in cycles 1-2.
  - flit_ready=0 from cycle 2 and flit 2 stalls.
  - Pulse credit_in in cycle 5: flit_ready=1 in cycle 6, flit 2 is accepted in cycle 6 and sent in cycle 7.
- Simultaneous credit and accept:
  - Setup: count=1; accept plus credit_in in the same cycle.
  - Required: count stays 1 and send_out pulses next cycle.
- Credit overflow: credit_in pulse at count=2 with no traffic.
  - Required: count stays 2 and err_credit_overflow=1 until reset.
- Framing: 3-flit packet dest=4'h5 followed by a single-flit packet dest=4'hA.
  - Required: err_dest_change=0 and pkt_count=2.
  - Then a 2-flit packet with dest 4'h3 then 4'h7: err_dest_change=1, and both flits are still sent.
- Stall stats (macro defined): 10 cycles of flit_valid=1 with zero credits.
  - Defined: stall_cycles=10.
  - Same stimulus with macro undefined: stall_cycles=0.
